xcvr_rx_width_upconverter_fifo: RTL and testbench

//  Single-clock RX-side width up-converter with integral FWFT buffer for the transceiver test system.

---
 rtl/xcvr_rx_width_upconverter_fifo.sv | 134 +++++++++++++
 tb/tb_xcvr_rx_width_upconverter_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_rx_width_upconverter_fifo.sv
// RX width up-converter: packs RATIO input words into one wide word and buffers
// the packed words in a DEPTH-entry first-word-fall-through FIFO with drop accounting.
module xcvr_rx_width_upconverter_fifo #(
  parameter int IN_W      = 64,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 16,
  parameter int MSW_FIRST = 0,
  parameter int AFULL_TH  = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic [IN_W*RATIO-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       wrfull,
  output logic                       almost_full,
  output logic                       overflow_sticky,
  output logic [15:0]                drop_count,
  input  logic                       clr_status
);

  localparam int OW = IN_W * RATIO;
  localparam int KW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [KW-1:0] lane_q, lane_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [OW-1:0] head_q, head_d;
  logic [OW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic [15:0]   drop_q, drop_d;
  logic          last_lane, push_req, push, pop, drop;
  int            slot;

  always_comb begin
    lane_d    = lane_q;
    acc_d     = acc_q;
    head_d    = head_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    drop_d    = drop_q;
    last_lane = (lane_q == KW'(RATIO - 1));
    slot      = (MSW_FIRST != 0) ? (RATIO - 1 - int'(lane_q)) : int'(lane_q);

    // acc_d doubles as the complete packed word on the last-lane cycle
    if (in_valid) begin
      acc_d[slot*IN_W +: IN_W] = in_data;
      lane_d = last_lane ? '0 : lane_q + KW'(1);
    end

    pop      = (cnt_q != '0) && out_ready;
    push_req = in_valid && last_lane;
    push     = push_req && ((cnt_q != CW'(DEPTH)) || pop);
    drop     = push_req && !push;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    // Head register tracks the entry visible after this edge; a word pushed
    // into an empty (or emptying) FIFO bypasses memory straight to the head.
    if (cnt_d != '0) begin
      if (push && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop)))
        head_d = acc_d;
      else
        head_d = mem_q[rd_ptr_d];
    end

    if (clr_status) begin
      sticky_d = 1'b0;
      drop_d   = '0;
    end else if (drop) begin
      sticky_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    if (flush) begin
      lane_d   = '0;
      acc_d    = '0;
      head_d   = head_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      sticky_d = sticky_q;
      drop_d   = drop_q;
      push     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q   <= '0;
      acc_q    <= '0;
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= acc_d;
  end

  assign out_data        = head_q;
  assign out_valid       = (cnt_q != '0);
  assign fill_level      = cnt_q;
  assign wrfull          = (cnt_q == CW'(DEPTH));
  assign almost_full     = (cnt_q >= CW'(AFULL_TH));
  assign overflow_sticky = sticky_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_xcvr_rx_width_upconverter_fifo.sv
// Randomized and directed bench for the RX width up-converter FIFO, checked
// against a queue-based reference model.
module tb_xcvr_rx_width_upconverter_fifo;

  localparam int IN_W = 64, RATIO = 2, DEPTH = 16, AFULL_TH = 12, MSW = 0;
  localparam int OW = IN_W * RATIO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, flush, out_ready, clr;
  logic [IN_W-1:0] in_data;
  logic [OW-1:0]   out_data;
  logic            out_valid, wrfull, almost_full, overflow_sticky;
  logic [4:0]      fill_level;
  logic [15:0]     drop_count;

  logic        iv2, rdy2, fl2_in, clr2;
  logic [15:0] d2;
  logic [63:0] od2;
  logic        ov2, wf2, af2, st2;
  logic [2:0]  fl2;
  logic [15:0] dc2;

  xcvr_rx_width_upconverter_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH),
    .MSW_FIRST(MSW), .AFULL_TH(AFULL_TH)) u_dut (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .wrfull(wrfull), .almost_full(almost_full),
    .overflow_sticky(overflow_sticky), .drop_count(drop_count), .clr_status(clr));

  xcvr_rx_width_upconverter_fifo #(.IN_W(16), .RATIO(4), .DEPTH(4),
    .MSW_FIRST(1), .AFULL_TH(3)) u_dut2 (
    .clk(clk), .reset(rst), .in_data(d2), .in_valid(iv2), .flush(fl2_in),
    .out_data(od2), .out_valid(ov2), .out_ready(rdy2),
    .fill_level(fl2), .wrfull(wf2), .almost_full(af2),
    .overflow_sticky(st2), .drop_count(dc2), .clr_status(clr2));

  int n_tests = 0;
  int n_fail  = 0;

  logic [IN_W-1:0] m_parts [RATIO];
  logic [OW-1:0]   m_q [$];
  logic [OW-1:0]   m_head;
  int              m_lane;
  bit              m_sticky;
  int              m_drop;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit iv, input logic [IN_W-1:0] d, input bit rdy,
                       input bit fl, input bit cl, input bit rs);
    bit pop, push, dropped;
    logic [OW-1:0] w;
    if (rs) begin
      m_q.delete(); m_lane = 0; m_sticky = 0; m_drop = 0; m_head = '0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    if (fl) begin
      m_lane = 0;
      m_q.delete();
      return;
    end
    push = 0; dropped = 0; w = '0;
    if (iv) begin
      m_parts[m_lane] = d;
      if (m_lane == RATIO - 1) begin push = 1; m_lane = 0; end
      else m_lane++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      for (int j = 0; j < RATIO; j++)
        w[((MSW != 0) ? (RATIO - 1 - j) : j) * IN_W +: IN_W] = m_parts[j];
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else dropped = 1;
    end
    if (cl) begin m_sticky = 0; m_drop = 0; end
    else if (dropped) begin
      m_sticky = 1;
      if (m_drop < 16'hFFFF) m_drop++;
    end
    if (m_q.size() > 0) m_head = m_q[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, out_valid, m_q.size() > 0);
    chk({tag, ".level"}, fill_level, m_q.size());
    chk({tag, ".full"},  wrfull, m_q.size() == DEPTH);
    chk({tag, ".afull"}, almost_full, m_q.size() >= AFULL_TH);
    chk({tag, ".sticky"}, overflow_sticky, m_sticky);
    chk({tag, ".drops"}, drop_count, m_drop);
    chk({tag, ".data"},  out_data, m_head);
  endtask

  task automatic step(input string tag, input bit iv, input logic [IN_W-1:0] d,
                      input bit rdy, input bit fl, input bit cl, input bit rs);
    in_valid = iv; in_data = d; out_ready = rdy; flush = fl; clr = cl; rst = rs;
    @(posedge clk);
    model(iv, d, rdy, fl, cl, rs);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [IN_W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [15:0] t2_w [7];
    bit          t2_v [7];
    logic [IN_W-1:0] x, y;
    rst = 1; in_valid = 0; in_data = '0; out_ready = 0; flush = 0; clr = 0;
    iv2 = 0; rdy2 = 0; fl2_in = 0; clr2 = 0; d2 = '0;
    m_lane = 0; m_sticky = 0; m_drop = 0; m_head = '0;
    @(negedge clk);
    step("rst", 0, '0, 0, 0, 0, 1);
    step("rst", 0, '0, 0, 0, 0, 1);
    step("idle", 0, '0, 0, 0, 0, 0);

    // T2 on the MSW-first, 4:1 instance with idle gaps between words
    t2_w = '{16'hAAA1, 16'h0, 16'hBBB2, 16'h0, 16'h0, 16'hCCC3, 16'hDDD4};
    t2_v = '{1, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      iv2 = t2_v[i]; d2 = t2_w[i];
      step("t2idle", 0, '0, 0, 0, 0, 0);
      chk("t2_valid", ov2, i == 6);
    end
    iv2 = 0;
    chk("t2_data", od2, 64'hAAA1_BBB2_CCC3_DDD4);
    chk("t2_level", fl2, 1);
    for (int i = 0; i < 3; i++) step("t2idle", 0, '0, 0, 0, 0, 0);
    chk("t2_noextra", fl2, 1);

    // T1
    step("t1a", 1, 64'h1111_1111_1111_1111, 0, 0, 0, 0);
    chk("t1_notyet", out_valid, 0);
    step("t1b", 1, 64'h2222_2222_2222_2222, 0, 0, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 128'h2222_2222_2222_2222_1111_1111_1111_1111);
    step("t1pop", 0, '0, 1, 0, 0, 0);

    // T3: overfill then drain
    for (int i = 0; i < 34; i++) step("t3fill", 1, rnd(), 0, 0, 0, 0);
    chk("t3_full", wrfull, 1);
    chk("t3_level", fill_level, 16);
    chk("t3_drops", drop_count, 1);
    chk("t3_sticky", overflow_sticky, 1);
    for (int i = 0; i < 18; i++) step("t3drain", 0, '0, 1, 0, 0, 0);

    // T4: simultaneous push and pop while full
    for (int i = 0; i < 32; i++) step("t4fill", 1, rnd(), 0, 0, 0, 0);
    step("t4x", 1, rnd(), 0, 0, 0, 0);
    step("t4y", 1, rnd(), 1, 0, 0, 0);
    chk("t4_level", fill_level, 16);
    chk("t4_drops", drop_count, 1);
    for (int i = 0; i < 17; i++) step("t4drain", 0, '0, 1, 0, 0, 0);

    // T5: flush discards the half-packed word
    step("t5a", 1, rnd(), 0, 0, 0, 0);
    step("t5fl", 1, rnd(), 1, 1, 0, 0);
    x = rnd(); y = rnd();
    step("t5x", 1, x, 0, 0, 0, 0);
    step("t5y", 1, y, 0, 0, 0, 0);
    chk("t5_data", out_data, {y, x});
    chk("t5_level", fill_level, 1);
    chk("t5_drops", drop_count, 1);
    step("t5clr", 0, '0, 1, 0, 1, 0);

    // T6: reset mid-stream
    for (int i = 0; i < 11; i++) step("t6fill", 1, rnd(), 0, 0, 0, 0);
    chk("t6_pre", fill_level, 5);
    step("t6rst", 1, rnd(), 1, 0, 0, 1);
    chk("t6_level", fill_level, 0);
    chk("t6_data", out_data, 0);
    x = rnd(); y = rnd();
    step("t6x", 1, x, 0, 0, 0, 0);
    step("t6y", 1, y, 0, 0, 0, 0);
    chk("t6_pair", out_data, {y, x});

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit fl, cl, rs;
      fl = ($urandom_range(0, 99) == 0);
      cl = !fl && ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step("rnd", $urandom_range(0, 9) < 7, rnd(),
           (i % 400 < 150) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6),
           fl, cl, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
